gio_int_ctrl: RTL and testbench

Interrupt controller that shares the single PicoBlaze `interrupt` input between up to eight GPIO interrupt sources, such as the `int_out` lines of interrupt-on-change input ports. It latches rising edges into a pending register and masks them. It raises `interrupt` for the lowest-numbered enabled pending source, then sequences the acknowledge and end-of-interrupt handshake. Mask, pending and active-ID registers sit on the I/O port bus; their read data feeds the input-port selector mux.

---
 rtl/gio_int_pkg.sv | 14 +
 rtl/gio_prio_enc.sv | 19 +
 rtl/gio_int_ctrl.sv | 103 ++++++++++
 tb/tb_gio_int_ctrl.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gio_int_pkg.sv
// Shared encodings for the GPIO interrupt controller: FSM states and default port addresses.
package gio_int_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    SERVICE = 2'd2
  } state_t;

  localparam logic [7:0] DEF_ADDR_MASK = 8'h10;
  localparam logic [7:0] DEF_ADDR_PEND = 8'h11;
  localparam logic [7:0] DEF_ADDR_ID   = 8'h12;

endpackage

// File: rtl/gio_prio_enc.sv
// Fixed-priority encoder, lowest set index wins; purely combinational, no handshake.
module gio_prio_enc #(
  parameter int NSRC = 4
) (
  input  logic [NSRC-1:0] req,
  output logic            valid,
  output logic [2:0]      idx
);

  always_comb begin
    valid = |req;
    idx   = 3'd0;
    // Scan downwards so the last hit, i.e. the lowest index, is kept.
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (req[i]) idx = 3'(i);
    end
  end

endmodule

// File: rtl/gio_int_ctrl.sv
// Shares the PicoBlaze interrupt line between NSRC edge-triggered sources with mask/pending/ID registers.
// Edge to interrupt in two clocks, port_out one clock behind address; sources are never stalled.
module gio_int_ctrl
  import gio_int_pkg::*;
#(
  parameter int         NSRC      = 4,
  parameter logic [7:0] ADDR_MASK = DEF_ADDR_MASK,
  parameter logic [7:0] ADDR_PEND = DEF_ADDR_PEND,
  parameter logic [7:0] ADDR_ID   = DEF_ADDR_ID
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [7:0]      address,
  input  logic [7:0]      value_in,
  input  logic            wen,
  input  logic            ren,
  output logic [7:0]      port_out,
  input  logic [NSRC-1:0] irq_in,
  output logic            interrupt,
  input  logic            int_ack
);

  state_t            state, state_nxt;
  logic [NSRC-1:0]   irq_d, pending, mask, rise, eligible;
  logic [NSRC-1:0]   w1c_clr, ack_clr, pending_nxt;
  logic [2:0]        active_id, win_idx;
  logic              win_vld;
  logic              wr_mask, wr_pend, wr_id, ack_fire;
  logic [7:0]        rd_dat;
  logic              unused_ok;

  // Reads are side-effect free, so the read strobe carries no information here.
  assign unused_ok = ^{ren, value_in};

  assign wr_mask  = wen && (address == ADDR_MASK);
  assign wr_pend  = wen && (address == ADDR_PEND);
  assign wr_id    = wen && (address == ADDR_ID);
  assign ack_fire = (state == ASSERT) && int_ack;

  assign rise     = irq_in & ~irq_d;
  assign eligible = pending & mask;
  assign w1c_clr  = wr_pend ? value_in[NSRC-1:0] : '0;

  always_comb begin
    ack_clr = '0;
    for (int i = 0; i < NSRC; i++) begin
      ack_clr[i] = ack_fire && (active_id == 3'(i));
    end
  end

  // New edges are OR-ed in last so a simultaneous set beats any clear.
  assign pending_nxt = (pending & ~w1c_clr & ~ack_clr) | rise;

  gio_prio_enc #(.NSRC(NSRC)) u_prio (
    .req   (eligible),
    .valid (win_vld),
    .idx   (win_idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_d     <= '0;
      pending   <= '0;
      mask      <= '0;
      active_id <= 3'd0;
      port_out  <= 8'h00;
    end else begin
      irq_d    <= irq_in;
      pending  <= pending_nxt;
      port_out <= rd_dat;
      if (wr_mask) mask <= value_in[NSRC-1:0];
      // active_id only moves on the IDLE->ASSERT hand-off and is frozen afterwards.
      if ((state == IDLE) && win_vld) active_id <= win_idx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (win_vld)  state_nxt = ASSERT;
      ASSERT:  if (int_ack)  state_nxt = SERVICE;
      SERVICE: if (wr_id)    state_nxt = IDLE;
      default:               state_nxt = IDLE;
    endcase
  end

  always_comb begin
    interrupt = (state == ASSERT);
  end

  always_comb begin
    rd_dat = 8'h00;
    if (address == ADDR_MASK)      rd_dat[NSRC-1:0] = mask;
    else if (address == ADDR_PEND) rd_dat[NSRC-1:0] = pending;
    else if (address == ADDR_ID)   rd_dat = {(state == SERVICE), 4'b0000, active_id};
  end

endmodule

// File: tb/tb_gio_int_ctrl.sv
// Directed scenarios plus a randomized run against a cycle-level behavioural model of the controller.
module tb_gio_int_ctrl;

  localparam logic [7:0] A_MASK = 8'h10;
  localparam logic [7:0] A_PEND = 8'h11;
  localparam logic [7:0] A_ID   = 8'h12;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] address = 8'h00;
  logic [7:0] value_in = 8'h00;
  logic       wen = 1'b0;
  logic       ren = 1'b0;
  logic       int_ack = 1'b0;
  logic [3:0] irq_in = 4'h0;
  logic [7:0] port_out;
  logic       interrupt;

  int n_checks = 0;
  int n_errors = 0;

  // Model: pending/mask as integers, state as 0=idle 1=waiting-for-ack 2=in-service.
  int m_pend, m_mask, m_state, m_id, m_irqd, m_pout;

  always #5 clk = ~clk;

  gio_int_ctrl #(.NSRC(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .address   (address),
    .value_in  (value_in),
    .wen       (wen),
    .ren       (ren),
    .port_out  (port_out),
    .irq_in    (irq_in),
    .interrupt (interrupt),
    .int_ack   (int_ack)
  );

  task automatic model_reset();
    m_pend = 0; m_mask = 0; m_state = 0; m_id = 0; m_irqd = 0; m_pout = 0;
  endtask

  // Advance one clock: evaluate the model on the current inputs, then sample #1 after the edge.
  task automatic tick();
    int rise, v, n_pend, n_mask, n_state, n_id, n_pout, elig;
    v      = int'(value_in);
    rise   = int'(irq_in) & ~m_irqd & 15;
    if (address == A_MASK)      n_pout = m_mask;
    else if (address == A_PEND) n_pout = m_pend;
    else if (address == A_ID)   n_pout = ((m_state == 2) ? 128 : 0) + m_id;
    else                        n_pout = 0;
    n_pend = m_pend;
    if (wen && address == A_PEND) n_pend = n_pend & ~v;
    if (m_state == 1 && int_ack)  n_pend = n_pend & ~(1 << m_id);
    n_pend = (n_pend | rise) & 15;
    n_mask = (wen && address == A_MASK) ? (v & 15) : m_mask;
    n_state = m_state;
    n_id    = m_id;
    elig    = m_pend & m_mask;
    if (m_state == 0 && elig != 0) begin
      n_state = 1;
      for (int i = 0; i < 4; i++) begin
        if (((elig >> i) & 1) == 1) begin n_id = i; break; end
      end
    end else if (m_state == 1 && int_ack) begin
      n_state = 2;
    end else if (m_state == 2 && wen && address == A_ID) begin
      n_state = 0;
    end
    @(posedge clk);
    #1;
    m_pend = n_pend; m_mask = n_mask; m_state = n_state; m_id = n_id;
    m_irqd = int'(irq_in); m_pout = n_pout;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    address = a; value_in = d; wen = 1'b1;
    tick();
    wen = 1'b0; value_in = 8'h00;
  endtask

  task automatic rd(input logic [7:0] a);
    address = a;
    tick();
  endtask

  task automatic ack();
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if (interrupt !== 1'b0) begin n_errors++; $display("FAIL reset_interrupt: got %b want 0", interrupt); end
    n_checks++;
    if (port_out !== 8'h00) begin n_errors++; $display("FAIL reset_port_out: got %h want 00", port_out); end
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_basic();
    wr(A_MASK, 8'h0F);
    irq_in = 4'b0100; tick();
    n_checks++;
    if (interrupt !== 1'b0) begin n_errors++; $display("FAIL basic_e0_quiet: got %b want 0", interrupt); end
    irq_in = 4'b0000; tick();
    n_checks++;
    if (interrupt !== 1'b1) begin n_errors++; $display("FAIL basic_e1_raise: got %b want 1", interrupt); end
    rd(A_ID);
    n_checks++;
    if (port_out !== 8'h02) begin n_errors++; $display("FAIL basic_id: got %h want 02", port_out); end
    ack();
    n_checks++;
    if (interrupt !== 1'b0) begin n_errors++; $display("FAIL basic_ack_drop: got %b want 0", interrupt); end
    rd(A_ID);
    n_checks++;
    if (port_out !== 8'h82) begin n_errors++; $display("FAIL basic_id_service: got %h want 82", port_out); end
    wr(A_ID, 8'h00);
    tick();
    n_checks++;
    if (interrupt !== 1'b0) begin n_errors++; $display("FAIL basic_eoi_empty: got %b want 0", interrupt); end
  endtask

  task automatic test_two_sources();
    irq_in = 4'b1010; tick();
    irq_in = 4'b0000; tick();
    n_checks++;
    if (interrupt !== 1'b1) begin n_errors++; $display("FAIL two_raise: got %b want 1", interrupt); end
    rd(A_ID);
    n_checks++;
    if (port_out !== 8'h01) begin n_errors++; $display("FAIL two_id_first: got %h want 01", port_out); end
    ack();
    rd(A_ID);
    n_checks++;
    if (port_out !== 8'h81) begin n_errors++; $display("FAIL two_id_service: got %h want 81", port_out); end
    rd(A_PEND);
    n_checks++;
    if (port_out !== 8'h08) begin n_errors++; $display("FAIL two_pending: got %h want 08", port_out); end
    wr(A_ID, 8'h00);
    n_checks++;
    if (interrupt !== 1'b0) begin n_errors++; $display("FAIL two_eoi_idle: got %b want 0", interrupt); end
    tick();
    n_checks++;
    if (interrupt !== 1'b1) begin n_errors++; $display("FAIL two_second_raise: got %b want 1", interrupt); end
    rd(A_ID);
    n_checks++;
    if (port_out !== 8'h03) begin n_errors++; $display("FAIL two_id_second: got %h want 03", port_out); end
    ack();
    wr(A_ID, 8'h00);
  endtask

  task automatic test_mask_late();
    wr(A_MASK, 8'h00);
    irq_in = 4'b0001; tick();
    irq_in = 4'b0000;
    rd(A_PEND);
    n_checks++;
    if (port_out !== 8'h01) begin n_errors++; $display("FAIL masked_pending: got %h want 01", port_out); end
    n_checks++;
    if (interrupt !== 1'b0) begin n_errors++; $display("FAIL masked_quiet: got %b want 0", interrupt); end
    wr(A_MASK, 8'h01);
    n_checks++;
    if (interrupt !== 1'b0) begin n_errors++; $display("FAIL unmask_edge: got %b want 0", interrupt); end
    tick();
    n_checks++;
    if (interrupt !== 1'b1) begin n_errors++; $display("FAIL unmask_raise: got %b want 1", interrupt); end
    ack();
    wr(A_ID, 8'h00);
  endtask

  task automatic test_set_wins();
    wr(A_MASK, 8'h00);
    address = A_PEND; value_in = 8'h01; wen = 1'b1; irq_in = 4'b0001;
    tick();
    wen = 1'b0; value_in = 8'h00; irq_in = 4'b0000;
    rd(A_PEND);
    n_checks++;
    if (port_out !== 8'h01) begin n_errors++; $display("FAIL set_wins: got %h want 01", port_out); end
    wr(A_PEND, 8'h0F);
    rd(A_PEND);
    n_checks++;
    if (port_out !== 8'h00) begin n_errors++; $display("FAIL w1c_clear: got %h want 00", port_out); end
  endtask

  task automatic test_assert_hold_and_reset();
    wr(A_MASK, 8'h0F);
    irq_in = 4'b0100; tick();
    irq_in = 4'b0000; tick();
    wr(A_MASK, 8'h00);
    n_checks++;
    if (interrupt !== 1'b1) begin n_errors++; $display("FAIL hold_after_mask: got %b want 1", interrupt); end
    wr(A_PEND, 8'h0F);
    n_checks++;
    if (interrupt !== 1'b1) begin n_errors++; $display("FAIL hold_after_w1c: got %b want 1", interrupt); end
    rd(A_ID);
    n_checks++;
    if (port_out !== 8'h02) begin n_errors++; $display("FAIL hold_id_frozen: got %h want 02", port_out); end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (interrupt !== 1'b0) begin n_errors++; $display("FAIL rst_in_assert: got %b want 0", interrupt); end
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    wr(A_MASK, 8'h0F);
    irq_in = 4'b0001; tick();
    irq_in = 4'b0000; tick();
    ack();
    rd(A_ID);
    n_checks++;
    if (port_out !== 8'h80) begin n_errors++; $display("FAIL service_id: got %h want 80", port_out); end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (port_out !== 8'h00) begin n_errors++; $display("FAIL rst_in_service_port: got %h want 00", port_out); end
    n_checks++;
    if (interrupt !== 1'b0) begin n_errors++; $display("FAIL rst_in_service_irq: got %b want 0", interrupt); end
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    rd(A_ID);
    n_checks++;
    if (port_out !== 8'h00) begin n_errors++; $display("FAIL rst_id_read: got %h want 00", port_out); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 2) == 0) irq_in = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 4))
        0:       address = A_MASK;
        1:       address = A_PEND;
        2, 3:    address = A_ID;
        default: address = 8'($urandom_range(0, 255));
      endcase
      wen      = ($urandom_range(0, 3) == 0);
      value_in = 8'($urandom_range(0, 255));
      int_ack  = ($urandom_range(0, 2) == 0);
      tick();
      n_checks++;
      if (interrupt !== (m_state == 1)) begin
        n_errors++;
        $display("FAIL rand_interrupt cycle %0d: got %b want %0d", c, interrupt, (m_state == 1));
      end
      n_checks++;
      if (port_out !== 8'(m_pout)) begin
        n_errors++;
        $display("FAIL rand_port_out cycle %0d: got %h want %h", c, port_out, 8'(m_pout));
      end
    end
    wen = 1'b0; int_ack = 1'b0; irq_in = 4'h0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_two_sources();
    test_mask_late();
    test_set_wins();
    test_assert_hold_and_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
